// File: rtl/bidir_pkg.sv
// Shared definitions for the half-duplex bus port and any peer-side models.
package bidir_pkg;

    typedef enum logic [1:0] {
        ST_LISTEN   = 2'd0,
        ST_TURN_ON  = 2'd1,
        ST_DRIVE    = 2'd2,
        ST_TURN_OFF = 2'd3
    } bus_state_e;

    // Turnaround counter width; a zero-cycle turnaround still needs one bit.
    function automatic int TURN_CNT_W(input int turn_cycles);
        return (turn_cycles < 1) ? 1 : $clog2(turn_cycles + 1);
    endfunction

endpackage

// File: rtl/bidir_bus_port_turn_timer.sv
// Loadable down-counter timing the dead cycles around a bus turnaround.
module turn_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] value_i,
    input  logic          dec_i,
    output logic          done_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Done one count early so a phase lasts exactly value_i cycles (minimum one).
    assign done_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/bidir_bus_port.sv
// Pad-side owner of one end of a tri-stated half-duplex bus, with dead cycles
// on every turnaround and peer priority whenever we are not yet driving.
module bidir_bus_port
    import bidir_pkg::*;
#(
    parameter int W           = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire  [W-1:0] bus_io,
    input  logic         peer_drive,
    input  logic [W-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [W-1:0] rx_data,
    output logic         rx_valid,
    output logic         bus_oe,
    output logic         collision,
    input  logic         clr_err
);

    localparam int            CW       = TURN_CNT_W(TURN_CYCLES);
    localparam logic [CW-1:0] TURN_VAL = CW'(TURN_CYCLES);

    bus_state_e   st_q, st_d;
    logic         oe_q, oe_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] rx_data_q, rx_data_d;
    logic         rx_valid_q, rx_valid_d;
    logic         coll_q, coll_d;
    logic         tmr_load, tmr_dec, tmr_done;

    turn_timer #(.CW(CW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (TURN_VAL),
        .dec_i   (tmr_dec),
        .done_o  (tmr_done)
    );

    assign tx_ready = (st_q == ST_DRIVE) && !peer_drive;

    always_comb begin
        st_d       = st_q;
        oe_d       = oe_q;
        out_d      = out_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        coll_d     = coll_q & ~clr_err;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        case (st_q)
            ST_LISTEN: begin
                oe_d = 1'b0;
                if (peer_drive) begin
                    rx_data_d  = bus_io;
                    rx_valid_d = 1'b1;
                end else if (tx_valid) begin
                    if (TURN_CYCLES == 0) begin
                        st_d = ST_DRIVE;
                    end else begin
                        st_d     = ST_TURN_ON;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_TURN_ON: begin
                oe_d = 1'b0;
                // Peer still owns the bus until we actually drive: yield quietly.
                if (peer_drive) begin
                    rx_data_d  = bus_io;
                    rx_valid_d = 1'b1;
                    st_d       = ST_LISTEN;
                end else if (tmr_done) begin
                    st_d = ST_DRIVE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (peer_drive) begin
                    coll_d   = 1'b1;
                    oe_d     = 1'b0;
                    st_d     = ST_TURN_OFF;
                    tmr_load = 1'b1;
                end else if (tx_valid) begin
                    out_d = tx_data;
                    oe_d  = 1'b1;
                end else begin
                    oe_d     = 1'b0;
                    st_d     = ST_TURN_OFF;
                    tmr_load = 1'b1;
                end
            end
            ST_TURN_OFF: begin
                oe_d = 1'b0;
                if (peer_drive) coll_d = 1'b1;
                if (tmr_done) begin
                    st_d = ST_LISTEN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                oe_d = 1'b0;
                st_d = ST_LISTEN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q       <= ST_LISTEN;
            oe_q       <= 1'b0;
            out_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            coll_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            coll_q     <= coll_d;
        end
    end

    // Reset clears oe_q asynchronously, so the pad releases without a clock.
    assign bus_io    = oe_q ? out_q : {W{1'bz}};
    assign bus_oe    = oe_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign collision = coll_q;

endmodule
